// File: rtl/clken_nco_seq.sv
// Multi-channel NCO clock-enable generator with a lock-qualified reset sequencer.
// Strobes run only while PLL lock has been stable for LOCK_CYC cycles.
module clken_nco_seq #(
    parameter int unsigned            NCH        = 3,
    parameter int unsigned            ACC_W      = 24,
    parameter int unsigned            LOCK_CYC   = 1024,
    parameter logic [NCH*ACC_W-1:0]   INC_INIT   = '0,
    parameter logic [NCH*ACC_W-1:0]   PHASE_INIT = '0
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             lock,
    input  logic             sync,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [2:0]       wr_ch,
    input  logic [ACC_W-1:0] wr_data,
    output logic [NCH-1:0]   ce,
    output logic             rst_out,
    output logic             running
);

    localparam int unsigned      CNT_W    = $clog2(LOCK_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYC - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StSettle,
        StRun
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]         inc_q   [NCH];
    logic [ACC_W-1:0]         inc_d   [NCH];
    logic [ACC_W-1:0]         phase_q [NCH];
    logic [ACC_W-1:0]         phase_d [NCH];
    logic [ACC_W-1:0]         acc_q   [NCH];
    logic [ACC_W-1:0]         acc_d   [NCH];
    logic [NCH-1:0][ACC_W:0]  sum;
    logic [NCH-1:0]           ce_q, ce_d;
    logic                     rst_out_q, rst_out_d;
    logic                     running_q, running_d;
    logic                     accumulate;
    logic                     wr_hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWaitLock: begin
                cnt_d = '0;
                if (lock) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (!lock) begin
                    state_d = StWaitLock;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock) begin
                    state_d = StWaitLock;
                end
            end
            default: state_d = StWaitLock;
        endcase
    end

    // Accumulate only when staying in RUN; RUN entry, lock loss and sync all reload phase.
    assign accumulate = (state_q == StRun) && (state_d == StRun) && !sync;
    assign wr_hit     = wr_en && (32'(wr_ch) < NCH);

    always_comb begin
        sum  = '0;
        ce_d = '0;
        for (int c = 0; c < NCH; c++) begin
            sum[c]     = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
            inc_d[c]   = inc_q[c];
            phase_d[c] = phase_q[c];
            if (accumulate) begin
                acc_d[c] = sum[c][ACC_W-1:0];
                ce_d[c]  = sum[c][ACC_W];
            end else begin
                acc_d[c] = phase_q[c];
            end
            if (wr_hit && (32'(wr_ch) == 32'(c))) begin
                if (wr_sel) begin
                    phase_d[c] = wr_data;
                end else begin
                    inc_d[c] = wr_data;
                end
            end
        end
    end

    assign rst_out_d = (state_d != StRun);
    assign running_d = (state_d == StRun);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            ce_q      <= '0;
            rst_out_q <= 1'b1;
            running_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                inc_q[c]   <= INC_INIT[c*ACC_W +: ACC_W];
                phase_q[c] <= PHASE_INIT[c*ACC_W +: ACC_W];
                acc_q[c]   <= PHASE_INIT[c*ACC_W +: ACC_W];
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ce_q      <= ce_d;
            rst_out_q <= rst_out_d;
            running_q <= running_d;
            for (int c = 0; c < NCH; c++) begin
                inc_q[c]   <= inc_d[c];
                phase_q[c] <= phase_d[c];
                acc_q[c]   <= acc_d[c];
            end
        end
    end

    assign ce      = ce_q;
    assign rst_out = rst_out_q;
    assign running = running_q;

endmodule

// File: tb/tb_clken_nco_seq.sv
// Self-checking bench for clken_nco_seq: per-cycle scoreboard against a behavioural
// model plus directed checks of release timing, strobe rates, sync and writes.
module tb_clken_nco_seq;

    localparam int unsigned NCH      = 2;
    localparam int unsigned ACC_W    = 8;
    localparam int unsigned LOCK_CYC = 4;
    localparam logic [15:0] INC_INIT   = {8'h40, 8'h80};
    localparam logic [15:0] PHASE_INIT = 16'h0000;

    logic             clk = 1'b0;
    logic             reset, lock, sync, wr_en, wr_sel;
    logic [2:0]       wr_ch;
    logic [ACC_W-1:0] wr_data;
    logic [NCH-1:0]   ce;
    logic             rst_out, running;

    always #5 clk = ~clk;

    clken_nco_seq #(
        .NCH       (NCH),
        .ACC_W     (ACC_W),
        .LOCK_CYC  (LOCK_CYC),
        .INC_INIT  (INC_INIT),
        .PHASE_INIT(PHASE_INIT)
    ) dut (
        .clkin  (clk),
        .reset  (reset),
        .lock   (lock),
        .sync   (sync),
        .wr_en  (wr_en),
        .wr_sel (wr_sel),
        .wr_ch  (wr_ch),
        .wr_data(wr_data),
        .ce     (ce),
        .rst_out(rst_out),
        .running(running)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int pulses0, pulses1;

    // Reference model state: 0 = wait lock, 1 = settle, 2 = run
    int         m_state, m_cnt;
    logic [7:0] m_inc [2];
    logic [7:0] m_phase [2];
    logic [7:0] m_acc [2];
    logic [1:0] m_ce;
    logic       m_rst, m_run;
    logic [3:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_init();
        m_state = 0;
        m_cnt   = 0;
        for (int c = 0; c < 2; c++) begin
            m_inc[c]   = INC_INIT[c*8 +: 8];
            m_phase[c] = PHASE_INIT[c*8 +: 8];
            m_acc[c]   = PHASE_INIT[c*8 +: 8];
        end
        m_ce  = 2'b00;
        m_rst = 1'b1;
        m_run = 1'b0;
    endtask

    // Predict the outputs after the coming edge and queue them.
    task automatic model_edge();
        int nxt;
        logic [8:0] s;
        if (reset) begin
            model_init();
        end else begin
            nxt = m_state;
            case (m_state)
                0: if (lock) begin nxt = 1; m_cnt = 0; end
                1: begin
                    if (!lock) nxt = 0;
                    else if (m_cnt == LOCK_CYC - 1) nxt = 2;
                    else m_cnt++;
                end
                default: if (!lock) nxt = 0;
            endcase
            for (int c = 0; c < 2; c++) begin
                if (m_state == 2 && nxt == 2 && !sync) begin
                    s        = {1'b0, m_acc[c]} + {1'b0, m_inc[c]};
                    m_ce[c]  = s[8];
                    m_acc[c] = s[7:0];
                end else begin
                    m_acc[c] = m_phase[c];
                    m_ce[c]  = 1'b0;
                end
            end
            if (wr_en && wr_ch < 3'd2) begin
                if (wr_sel) m_phase[wr_ch[0]] = wr_data;
                else        m_inc[wr_ch[0]]   = wr_data;
            end
            m_state = nxt;
            m_rst   = (nxt != 2);
            m_run   = (nxt == 2);
        end
        exp_q.push_back({m_ce, m_rst, m_run});
    endtask

    task automatic step();
        logic [3:0] e;
        model_edge();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("cycle", {28'd0, ce, rst_out, running}, {28'd0, e});
        pulses0 += int'(ce[0]);
        pulses1 += int'(ce[1]);
    endtask

    task automatic step_ce(input string tag, input logic [1:0] e);
        step();
        check_eq(tag, {30'd0, ce}, {30'd0, e});
    endtask

    task automatic write(input logic sel, input logic [2:0] ch, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_ch   = ch;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    // Counts edges from the first lock-high edge until rst_out falls (bounded).
    task automatic wait_release(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (rst_out !== 1'b0 && n < 20);
        check_eq(tag, 32'(n - 1), 32'd4);
    endtask

    task automatic count_pulses(input int cycles);
        pulses0 = 0;
        pulses1 = 0;
        repeat (cycles) step();
    endtask

    initial begin
        reset = 1'b1; lock = 1'b0; sync = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_ch = 3'd0; wr_data = 8'h00;
        pulses0 = 0; pulses1 = 0;
        model_init();
        repeat (2) step();
        check_eq("reset_rst_out", {31'd0, rst_out}, 32'd1);
        check_eq("reset_running", {31'd0, running}, 32'd0);
        check_eq("reset_ce", {30'd0, ce}, 32'd0);

        // Lock acquisition and nominal rates
        reset = 1'b0;
        lock  = 1'b1;
        wait_release("t1_release");
        check_eq("t1_running", {31'd0, running}, 32'd1);
        count_pulses(64);
        check_eq("t1_ce0_count", 32'(pulses0), 32'd32);
        check_eq("t1_ce1_count", 32'(pulses1), 32'd16);

        // One-cycle lock drop
        lock = 1'b0;
        step();
        check_eq("t2_rst_out", {31'd0, rst_out}, 32'd1);
        check_eq("t2_ce", {30'd0, ce}, 32'd0);
        lock = 1'b1;
        wait_release("t2_release");
        step_ce("t2_run1", 2'b00);
        step_ce("t2_run2", 2'b01);
        step_ce("t2_run3", 2'b00);
        step_ce("t2_run4", 2'b11);

        // Runtime increment changes
        write(1'b0, 3'd1, 8'h55);
        count_pulses(256);
        check_eq("t3_ce1_85", 32'(pulses1), 32'd85);
        write(1'b0, 3'd1, 8'h00);
        count_pulses(64);
        check_eq("t3_ce1_zero", 32'(pulses1), 32'd0);
        check_eq("t3_ce0_count", 32'(pulses0), 32'd32);

        // Phase offset and sync
        write(1'b0, 3'd1, 8'h40);
        write(1'b1, 3'd0, 8'h80);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("t4_sync_edge", {30'd0, ce}, 32'd0);
        step_ce("t4_ph1", 2'b01);
        step_ce("t4_ph2", 2'b00);
        step_ce("t4_ph3", 2'b01);
        step_ce("t4_ph4", 2'b10);
        wr_en = 1'b1; wr_sel = 1'b1; wr_ch = 3'd0; wr_data = 8'h00; sync = 1'b1;
        step();
        wr_en = 1'b0; sync = 1'b0;
        check_eq("t4_sync_wr_edge", {30'd0, ce}, 32'd0);
        step_ce("t4_old1", 2'b01);
        step_ce("t4_old2", 2'b00);
        step_ce("t4_old3", 2'b01);
        step_ce("t4_old4", 2'b10);
        sync = 1'b1;
        step();
        sync = 1'b0;
        step_ce("t4_new1", 2'b00);
        step_ce("t4_new2", 2'b01);
        step_ce("t4_new3", 2'b00);
        step_ce("t4_new4", 2'b11);

        // Out-of-range channel writes, then reset mid-RUN
        write(1'b0, 3'd5, 8'hFF);
        write(1'b1, 3'd5, 8'hFF);
        sync = 1'b1;
        step();
        sync = 1'b0;
        step_ce("t5_ign1", 2'b00);
        step_ce("t5_ign2", 2'b01);
        step_ce("t5_ign3", 2'b00);
        step_ce("t5_ign4", 2'b11);
        write(1'b0, 3'd0, 8'h20);
        repeat (3) step();
        reset = 1'b1;
        step();
        check_eq("t5_rst_out", {31'd0, rst_out}, 32'd1);
        check_eq("t5_running", {31'd0, running}, 32'd0);
        check_eq("t5_ce", {30'd0, ce}, 32'd0);
        reset = 1'b0;
        wait_release("t5_release");
        count_pulses(64);
        check_eq("t5_ce0_init_inc", 32'(pulses0), 32'd32);
        check_eq("t5_ce1_init_inc", 32'(pulses1), 32'd16);

        // Lock glitch during SETTLE at cnt=2
        lock = 1'b0;
        step();
        lock = 1'b1;
        repeat (3) step();
        lock = 1'b0;
        step();
        check_eq("t6_glitch_rst", {31'd0, rst_out}, 32'd1);
        lock = 1'b1;
        wait_release("t6_release");
        check_eq("t6_running", {31'd0, running}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
